cpu_boot_loader: RTL

- Upstream companion of the pipelined RISC-V cpu.
- Accepts a word stream carrying a program image and writes it into instruction and data memory through the cpu external ports (addr_ext/wen_ext, addr_ext_2/wen_ext_2).
- Then drives cpu enable for a programmed cycle budget, and finally reads back a data-memory window and streams it out.
- Used as the bring-up/test harness front end for the core.

---
 rtl/cpu_boot_loader_pkg.sv | 25 ++
 rtl/cpu_boot_loader_stream_out_reg.sv | 28 ++
 rtl/cpu_boot_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_boot_loader_pkg.sv
// Shared types and constants for the boot loader.
package cpu_boot_loader_pkg;

  localparam int unsigned IMEM_SHIFT = 2;   // imem word index -> byte address
  localparam int unsigned DMEM_SHIFT = 3;   // dmem word index -> byte address
  localparam int unsigned IDX_W      = 11;  // word indices / counts (up to 1024)
  localparam int unsigned RUN_W      = 32;  // run cycle counter
  localparam int unsigned DATA_W     = 64;  // dump word width

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_I,
    S_HDR_D,
    S_LOAD_I,
    S_LOAD_D_LO,
    S_LOAD_D_HI,
    S_RUN,
    S_DUMP_REQ,
    S_DUMP_WAIT,
    S_DUMP_OUT,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/cpu_boot_loader_stream_out_reg.sv
// Output holding register with valid/ready.
//   load/load_data : capture a new word and raise valid
//   valid/ready    : downstream handshake; data held while stalled
module stream_out_reg
  import cpu_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot loader: streams a program image into imem/dmem, runs the cpu for a
// programmed cycle budget, then dumps a dmem window.
//   start/run_cycles/dump_words : sequence control
//   in_*                        : 32-bit input stream
//   out_*                       : 64-bit dump stream
//   *_ext / *_ext_2             : imem / dmem external ports
//   cpu_enable, busy, done, error
module cpu_boot_loader
  import cpu_boot_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [31:0] run_cycles,
  input  logic [10:0] dump_words,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [IDX_W-1:0] DUMP_LIM = IDX_W'(DMEM_DEPTH);

  state_t           state, state_nx;
  logic [RUN_W-1:0] run_q, run_cnt;
  logic [IDX_W-1:0] dump_q, n_i, n_d, idx, idx_nx, dump_idx, dump_nx;
  logic [IDX_W-1:0] waddr_i, waddr_d;
  logic [31:0]      lo_q;
  logic             xfer, run_end, out_xfer, ld_out;

  assign xfer     = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign idx_nx   = idx + IDX_W'(1);
  assign dump_nx  = dump_idx + IDX_W'(1);
  assign run_end  = (run_cnt == run_q);
  assign ld_out   = (state == S_DUMP_WAIT);

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_HDR_I;
      S_HDR_I: if (xfer) state_nx = (in_data > IMEM_DEPTH) ? S_ERROR : S_HDR_D;
      S_HDR_D: if (xfer) begin
        if (in_data > DMEM_DEPTH) state_nx = S_ERROR;
        else if (n_i != '0)       state_nx = S_LOAD_I;
        else if (in_data != '0)   state_nx = S_LOAD_D_LO;
        else                      state_nx = S_RUN;
      end
      S_LOAD_I: if (xfer && idx_nx == n_i)
        state_nx = (n_d == '0) ? S_RUN : S_LOAD_D_LO;
      S_LOAD_D_LO: if (xfer) state_nx = S_LOAD_D_HI;
      S_LOAD_D_HI: if (xfer) state_nx = (idx_nx == n_d) ? S_RUN : S_LOAD_D_LO;
      S_RUN: if (run_end) state_nx = (dump_q == '0) ? S_DONE : S_DUMP_REQ;
      S_DUMP_REQ:  state_nx = S_DUMP_WAIT;
      S_DUMP_WAIT: state_nx = S_DUMP_OUT;
      S_DUMP_OUT: if (out_ready) state_nx = (dump_nx == dump_q) ? S_DONE : S_DUMP_REQ;
      S_ERROR: state_nx = S_ERROR;
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    ren_ext_2 = 1'b0;
    case (state)
      S_HDR_I, S_HDR_D, S_LOAD_I, S_LOAD_D_LO, S_LOAD_D_HI: in_ready = 1'b1;
      S_DUMP_REQ: ren_ext_2 = 1'b1;
      S_IDLE:  busy = 1'b0;
      S_DONE:  begin busy = 1'b0; done = 1'b1; end
      S_ERROR: begin busy = 1'b0; error = 1'b1; end
      default: ;
    endcase
  end

  assign ren_ext    = 1'b0;
  assign addr_ext   = 64'(waddr_i) << IMEM_SHIFT;
  assign addr_ext_2 = ((state == S_DUMP_REQ) ? 64'(dump_idx) : 64'(waddr_d)) << DMEM_SHIFT;

  // Datapath. cpu_enable is registered so it rises one cycle into RUN, after
  // the final load write pulse; RUN therefore holds run_cycles+1 cycles.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      run_q       <= '0;
      run_cnt     <= '0;
      dump_q      <= '0;
      n_i         <= '0;
      n_d         <= '0;
      idx         <= '0;
      dump_idx    <= '0;
      waddr_i     <= '0;
      waddr_d     <= '0;
      lo_q        <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      cpu_enable  <= 1'b0;
    end else begin
      wen_ext    <= 1'b0;
      wen_ext_2  <= 1'b0;
      cpu_enable <= (state == S_RUN) && !run_end;
      if (state == S_RUN) begin
        if (!run_end) run_cnt <= run_cnt + RUN_W'(1);
      end else begin
        run_cnt <= '0;
      end
      case (state)
        S_IDLE, S_DONE: if (start) begin
          run_q    <= run_cycles;
          dump_q   <= (dump_words > DUMP_LIM) ? DUMP_LIM : dump_words;
          idx      <= '0;
          dump_idx <= '0;
        end
        S_HDR_I: if (xfer) n_i <= in_data[IDX_W-1:0];
        S_HDR_D: if (xfer) begin
          n_d <= in_data[IDX_W-1:0];
          idx <= '0;
        end
        S_LOAD_I: if (xfer) begin
          wen_ext   <= 1'b1;
          waddr_i   <= idx;
          wdata_ext <= in_data;
          idx       <= (idx_nx == n_i) ? '0 : idx_nx;
        end
        S_LOAD_D_LO: if (xfer) lo_q <= in_data;
        S_LOAD_D_HI: if (xfer) begin
          wen_ext_2   <= 1'b1;
          waddr_d     <= idx;
          wdata_ext_2 <= {in_data, lo_q};
          idx         <= idx_nx;
        end
        S_DUMP_OUT: if (out_xfer) dump_idx <= dump_nx;
        default: ;
      endcase
    end
  end

  stream_out_reg u_out (
    .clk       (clk),
    .arst_n    (arst_n),
    .load      (ld_out),
    .load_data (rdata_ext_2),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data)
  );

endmodule
